// File: rtl/datapath_controller.sv
// datapath_controller: instruction register, decoder and sequencing FSM
// that drives every control input of the lab datapath.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   in, load           instruction word and IR load enable (only while w=1)
//   s                  start, sampled only while idle in WAIT
//   w                  idle/ready flag
//   readnum, writenum  register-file read/write index
//   write, vsel        register-file write strobe and write-back source
//   datapath_in        sign-extended IR[7:0]
//   loada/b/c, loads   pipeline register and status load strobes
//   asel, bsel         ALU operand selects
//   shift, ALUop       shifter and ALU operation
//   illegal            sticky undefined-encoding flag (DP_CTRL_ILLEGAL_EN)
//
// Build option: define DP_CTRL_ILLEGAL_EN to add the `illegal` output.

module datapath_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        s,
   output logic        w,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic        vsel,
   output logic [15:0] datapath_in,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop
`ifdef DP_CTRL_ILLEGAL_EN
   ,
   output logic        illegal
`endif
);

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_WRITE_IMM,
      S_GET_A,
      S_GET_B,
      S_ALU,
      S_WRITE_REG
   } state_t;

   state_t      state_q;
   logic [15:0] ir_q;

   logic is_mov_imm;
   logic is_mov_reg;
   logic is_alu;
   logic is_cmp;
   logic is_legal;

   assign is_mov_imm = (ir_q[15:13] == 3'b110)
                     && (ir_q[12:11] == 2'b10);
   assign is_mov_reg = (ir_q[15:13] == 3'b110)
                     && (ir_q[12:11] == 2'b00);
   assign is_alu     = (ir_q[15:13] == 3'b101);
   assign is_cmp     = is_alu && (ir_q[12:11] == 2'b01);
   assign is_legal   = is_mov_imm | is_mov_reg | is_alu;

   assign datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};

   // B operand is always taken from the shifter in this instruction set.
   assign bsel = 1'b0;

   // Outputs are registered: each branch loads the values that belong
   // to the state being entered, so they are valid for that whole cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_WAIT;
         ir_q     <= 16'h0000;
         w        <= 1'b1;
         readnum  <= 3'd0;
         writenum <= 3'd0;
         write    <= 1'b0;
         vsel     <= 1'b0;
         loada    <= 1'b0;
         loadb    <= 1'b0;
         loadc    <= 1'b0;
         loads    <= 1'b0;
         asel     <= 1'b0;
         shift    <= 2'b00;
         ALUop    <= 2'b00;
      end else begin
         w        <= 1'b0;
         readnum  <= 3'd0;
         writenum <= 3'd0;
         write    <= 1'b0;
         vsel     <= 1'b0;
         loada    <= 1'b0;
         loadb    <= 1'b0;
         loadc    <= 1'b0;
         loads    <= 1'b0;
         asel     <= 1'b0;
         shift    <= 2'b00;
         ALUop    <= 2'b00;
         unique case (state_q)
            S_WAIT: begin
               if (load) ir_q <= in;
               if (s) state_q <= S_DECODE;
               else   w       <= 1'b1;
            end
            S_DECODE: begin
               if (is_mov_imm) begin
                  state_q  <= S_WRITE_IMM;
                  writenum <= ir_q[10:8];
                  vsel     <= 1'b1;
                  write    <= 1'b1;
               end else if (is_mov_reg) begin
                  state_q <= S_GET_B;
                  readnum <= ir_q[2:0];
                  loadb   <= 1'b1;
               end else if (is_alu) begin
                  state_q <= S_GET_A;
                  readnum <= ir_q[10:8];
                  loada   <= 1'b1;
               end else begin
                  state_q <= S_WAIT;
                  w       <= 1'b1;
               end
            end
            S_GET_A: begin
               state_q <= S_GET_B;
               readnum <= ir_q[2:0];
               loadb   <= 1'b1;
            end
            S_GET_B: begin
               state_q <= S_ALU;
               shift   <= ir_q[4:3];
               loadc   <= 1'b1;
               // MOV reg passes B through as 0 + B
               asel    <= is_mov_reg;
               ALUop   <= is_mov_reg ? 2'b00 : ir_q[12:11];
               loads   <= is_cmp;
            end
            S_ALU: begin
               if (is_cmp) begin
                  state_q <= S_WAIT;
                  w       <= 1'b1;
               end else begin
                  state_q  <= S_WRITE_REG;
                  writenum <= ir_q[7:5];
                  write    <= 1'b1;
               end
            end
            S_WRITE_IMM,
            S_WRITE_REG: begin
               state_q <= S_WAIT;
               w       <= 1'b1;
            end
            default: begin
               state_q <= S_WAIT;
               w       <= 1'b1;
            end
         endcase
      end
   end

`ifdef DP_CTRL_ILLEGAL_EN
   logic illegal_q;

   always_ff @(posedge clk) begin
      if (reset)
         illegal_q <= 1'b0;
      else if (state_q == S_WAIT && load)
         illegal_q <= 1'b0;
      else if (state_q == S_DECODE && !is_legal)
         illegal_q <= 1'b1;
   end

   assign illegal = illegal_q;
`endif

endmodule
